// File: rtl/integrador_velocidad.sv
// Integrates signed acceleration samples into a saturating velocity, using a
// serial shift-add multiplier. Define INTEGRADOR_TRAPECIO_EN for the trapezoidal rule.
module integrador_velocidad #(
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 32,
    parameter int VEL_W    = 32,
    parameter int DT_SHIFT = 26,
    parameter int TIMEOUT  = 500000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [ACC_W-1:0] aceleracion,
    input  logic                    muestraValida,
    input  logic                    limpiar,
    output logic signed [VEL_W-1:0] velocidad,
    output logic                    impulso,
    output logic                    ocupado,
    output logic                    saturado,
    output logic [CNT_W-1:0]        ciclos
);

    localparam int PW = ACC_W + CNT_W;
    localparam int SW = PW + VEL_W + 2;
    localparam int BW = $clog2(CNT_W + 1);
    localparam logic [BW-1:0]        LAST_BIT = BW'(CNT_W - 1);
    localparam logic [CNT_W-1:0]     T_MAX    = CNT_W'(TIMEOUT);
    localparam logic signed [SW-1:0] V_MAX    = {{(SW-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
    localparam logic signed [SW-1:0] V_MIN    = {{(SW-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, ACCUM, DONE} state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] mplier;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    prod;
    logic [BW-1:0]    bit_cnt;
    logic             neg_r;
    logic [VEL_W-1:0] v_new;
    logic             sat_new;

    logic [ACC_W:0]   mag_in;
    logic             neg_in;

`ifdef INTEGRADOR_TRAPECIO_EN
    logic signed [ACC_W-1:0] a_prev;
    logic signed [ACC_W-1:0] a_lat;
    logic [ACC_W:0]          suma;
    logic [ACC_W:0]          abs_suma;

    // Average halves the magnitude so the result truncates toward zero for either sign.
    always_comb begin
        suma     = {a_prev[ACC_W-1], a_prev} + {aceleracion[ACC_W-1], aceleracion};
        neg_in   = suma[ACC_W];
        abs_suma = neg_in ? (~suma + 1'b1) : suma;
        mag_in   = abs_suma >> 1;
    end
`else
    logic [ACC_W:0] a_ext;

    always_comb begin
        a_ext  = {aceleracion[ACC_W-1], aceleracion};
        neg_in = a_ext[ACC_W];
        mag_in = neg_in ? (~a_ext + 1'b1) : a_ext;
    end
`endif

    logic [PW-1:0]        mag_sh;
    logic signed [SW-1:0] vel_ext;
    logic signed [SW-1:0] delta;
    logic signed [SW-1:0] v_sum;
    logic                 over_hi;
    logic                 over_lo;

    always_comb begin
        mag_sh  = prod >> DT_SHIFT;
        vel_ext = {{(SW-VEL_W){velocidad[VEL_W-1]}}, velocidad};
        delta   = {{(SW-PW){1'b0}}, mag_sh};
        v_sum   = neg_r ? (vel_ext - delta) : (vel_ext + delta);
        over_hi = v_sum > V_MAX;
        over_lo = v_sum < V_MIN;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (limpiar) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (muestraValida) next_state = MULT;
                MULT:    if (bit_cnt == LAST_BIT) next_state = ACCUM;
                ACCUM:   next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || limpiar) begin
            velocidad <= '0;
            impulso   <= 1'b0;
            ocupado   <= 1'b0;
            saturado  <= 1'b0;
            counter   <= '0;
            mplier    <= '0;
            mcand     <= '0;
            prod      <= '0;
            bit_cnt   <= '0;
            neg_r     <= 1'b0;
            v_new     <= '0;
            sat_new   <= 1'b0;
`ifdef INTEGRADOR_TRAPECIO_EN
            a_prev    <= '0;
            a_lat     <= '0;
`endif
            // ciclos survives limpiar; only reset clears it.
            if (reset) ciclos <= '0;
        end else begin
            impulso <= 1'b0;
            if (state == IDLE && muestraValida) counter <= '0;
            else if (counter != T_MAX)          counter <= counter + 1'b1;

            case (state)
                IDLE: begin
                    if (muestraValida) begin
                        mcand   <= {{(CNT_W-1){1'b0}}, mag_in};
                        mplier  <= counter;
                        ciclos  <= counter;
                        prod    <= '0;
                        bit_cnt <= '0;
                        neg_r   <= neg_in;
                        ocupado <= 1'b1;
`ifdef INTEGRADOR_TRAPECIO_EN
                        a_lat   <= aceleracion;
`endif
                    end
                end
                MULT: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                ACCUM: begin
                    if (over_hi)      v_new <= V_MAX[VEL_W-1:0];
                    else if (over_lo) v_new <= V_MIN[VEL_W-1:0];
                    else              v_new <= v_sum[VEL_W-1:0];
                    sat_new <= over_hi | over_lo;
                end
                DONE: begin
                    velocidad <= v_new;
                    saturado  <= saturado | sat_new;
                    impulso   <= 1'b1;
                    ocupado   <= 1'b0;
`ifdef INTEGRADOR_TRAPECIO_EN
                    a_prev    <= a_lat;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_integrador_velocidad.sv
// Self-checking bench for integrador_velocidad: directed scenarios plus random samples
// against an arithmetic reference model (honours INTEGRADOR_TRAPECIO_EN).
module tb_integrador_velocidad;

    localparam int ACC_W    = 12;
    localparam int CNT_W    = 8;
    localparam int VEL_W    = 16;
    localparam int DT_SHIFT = 4;
    localparam int TIMEOUT  = 200;
    localparam int LAT      = CNT_W + 2;

    logic                    clock = 1'b0;
    logic                    reset;
    logic signed [ACC_W-1:0] aceleracion;
    logic                    muestraValida;
    logic                    limpiar;
    logic signed [VEL_W-1:0] velocidad;
    logic                    impulso;
    logic                    ocupado;
    logic                    saturado;
    logic [CNT_W-1:0]        ciclos;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;

    // Reference model state: edge of last reset/limpiar/accepted sample, velocity, flags.
    int ref_evt   = 0;
    int ref_vel   = 0;
    int ref_aprev = 0;
    int ref_ciclos = 0;
    bit ref_sat   = 1'b0;

    always #5 clock = ~clock;

    integrador_velocidad #(
        .ACC_W(ACC_W), .CNT_W(CNT_W), .VEL_W(VEL_W),
        .DT_SHIFT(DT_SHIFT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .aceleracion(aceleracion),
        .muestraValida(muestraValida),
        .limpiar(limpiar),
        .velocidad(velocidad),
        .impulso(impulso),
        .ocupado(ocupado),
        .saturado(saturado),
        .ciclos(ciclos)
    );

    task automatic tick();
        @(posedge clock);
        edge_no++;
        #1;
    endtask

    function automatic void model_apply(input int a, input int dt);
        int m, mag, d, v;
        bit neg;
`ifdef INTEGRADOR_TRAPECIO_EN
        m   = ref_aprev + a;
        neg = (m < 0);
        mag = (neg ? -m : m) / 2;
        ref_aprev = a;
`else
        m   = a;
        neg = (m < 0);
        mag = neg ? -m : m;
`endif
        d = (mag * dt) / (1 << DT_SHIFT);
        v = ref_vel + (neg ? -d : d);
        if (v > 32767) begin
            v = 32767;
            ref_sat = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            ref_sat = 1'b1;
        end
        ref_vel = v;
    endfunction

    // Waits until at least dt_target cycles have elapsed, strobes one sample, optionally
    // adds an extra (to be ignored) strobe 'extra' cycles after acceptance, checks the result.
    task automatic run_sample(input int a, input int dt_target, input int extra, input string tag);
        int dt, n_imp;
        aceleracion = ACC_W'(a);
        while (edge_no - ref_evt < dt_target) tick();
        muestraValida = 1'b1;
        tick();
        muestraValida = 1'b0;
        dt = edge_no - 1 - ref_evt;
        if (dt > TIMEOUT) dt = TIMEOUT;
        ref_evt    = edge_no;
        ref_ciclos = dt;
        model_apply(a, dt);

        n_checks++;
        if (ocupado !== 1'b1) $display("FAIL %s ocupado_after_accept got=%b exp=1", tag, ocupado);
        else n_pass++;
        n_checks++;
        if (ciclos !== CNT_W'(dt)) $display("FAIL %s ciclos got=%0d exp=%0d", tag, ciclos, dt);
        else n_pass++;

        n_imp = 0;
        for (int k = 1; k <= LAT; k++) begin
            muestraValida = (k == extra);
            aceleracion   = ACC_W'($urandom_range(0, 4095));
            tick();
            if (impulso === 1'b1) n_imp++;
            if (k == LAT - 1) begin
                n_checks++;
                if (impulso !== 1'b0 || ocupado !== 1'b1)
                    $display("FAIL %s early_impulso got=%b/%b exp=0/1", tag, impulso, ocupado);
                else n_pass++;
            end
        end
        muestraValida = 1'b0;

        n_checks++;
        if (impulso !== 1'b1) $display("FAIL %s impulso_latency got=%b exp=1", tag, impulso);
        else n_pass++;
        n_checks++;
        if (velocidad !== VEL_W'(ref_vel)) $display("FAIL %s velocidad got=%0d exp=%0d", tag, velocidad, ref_vel);
        else n_pass++;
        n_checks++;
        if (saturado !== ref_sat) $display("FAIL %s saturado got=%b exp=%b", tag, saturado, ref_sat);
        else n_pass++;
        n_checks++;
        if (ocupado !== 1'b0 || n_imp != 1)
            $display("FAIL %s done_state ocupado=%b impulsos=%0d exp=0/1", tag, ocupado, n_imp);
        else n_pass++;
        tick();
        n_checks++;
        if (impulso !== 1'b0) $display("FAIL %s impulso_width got=%b exp=0", tag, impulso);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        limpiar = 1'b0;
        muestraValida = 1'b0;
        aceleracion = '0;
        repeat (3) tick();
        n_checks++;
        if (velocidad !== '0 || impulso !== 1'b0 || ocupado !== 1'b0 || saturado !== 1'b0 || ciclos !== '0)
            $display("FAIL reset_values got v=%0d i=%b o=%b s=%b c=%0d exp all 0",
                     velocidad, impulso, ocupado, saturado, ciclos);
        else n_pass++;
        reset = 1'b0;
        ref_evt = edge_no;
        ref_vel = 0;
        ref_aprev = 0;
        ref_sat = 1'b0;
        ref_ciclos = 0;
    endtask

`ifdef INTEGRADOR_TRAPECIO_EN
    task automatic test_trapecio();
        run_sample(32, 16, 0, "trap_first");
        n_checks++;
        if (velocidad !== 16'sd16) $display("FAIL trap_first_const got=%0d exp=16", velocidad);
        else n_pass++;
        run_sample(32, 16, 0, "trap_second");
        n_checks++;
        if (velocidad !== 16'sd48) $display("FAIL trap_second_const got=%0d exp=48", velocidad);
        else n_pass++;
    endtask
`else
    task automatic test_plan();
        run_sample(16, 32, 0, "plan_pos");
        n_checks++;
        if (velocidad !== 16'sd32 || ciclos !== 8'd32)
            $display("FAIL plan_pos_const got v=%0d c=%0d exp v=32 c=32", velocidad, ciclos);
        else n_pass++;
        run_sample(-16, 32, 0, "plan_neg");
        n_checks++;
        if (velocidad !== 16'sd0) $display("FAIL plan_neg_const got=%0d exp=0", velocidad);
        else n_pass++;
        run_sample(-1, 15, 0, "plan_trunc");
        n_checks++;
        if (velocidad !== 16'sd0) $display("FAIL plan_trunc_const got=%0d exp=0", velocidad);
        else n_pass++;
        run_sample(2047, 300, 0, "plan_cap");
        n_checks++;
        if (velocidad !== 16'sd25587 || ciclos !== 8'd200)
            $display("FAIL plan_cap_const got v=%0d c=%0d exp v=25587 c=200", velocidad, ciclos);
        else n_pass++;
        run_sample(2047, 300, 0, "plan_sat");
        n_checks++;
        if (velocidad !== 16'sd32767 || saturado !== 1'b1)
            $display("FAIL plan_sat_const got v=%0d s=%b exp v=32767 s=1", velocidad, saturado);
        else n_pass++;
        run_sample(-2047, 200, 0, "plan_back");
        n_checks++;
        if (velocidad !== 16'sd7180 || saturado !== 1'b1)
            $display("FAIL plan_back_const got v=%0d s=%b exp v=7180 s=1", velocidad, saturado);
        else n_pass++;
    endtask
`endif

    task automatic test_back_to_back();
        run_sample(100, 20, 3, "ignore_mult");
        run_sample(-300, 30, 10, "ignore_done");
        run_sample(-2048, 120, 0, "most_negative");
        run_sample(50, 11, 0, "min_gap");
    endtask

    task automatic test_limpiar();
        int dt, n_imp;
        aceleracion = 12'sd400;
        while (edge_no - ref_evt < 20) tick();
        muestraValida = 1'b1;
        tick();
        muestraValida = 1'b0;
        dt = edge_no - 1 - ref_evt;
        if (dt > TIMEOUT) dt = TIMEOUT;
        ref_ciclos = dt;
        repeat (4) tick();
        limpiar = 1'b1;
        tick();
        limpiar = 1'b0;
        ref_evt = edge_no;
        ref_vel = 0;
        ref_sat = 1'b0;
        ref_aprev = 0;
        n_checks++;
        if (velocidad !== '0 || saturado !== 1'b0 || ocupado !== 1'b0 || impulso !== 1'b0)
            $display("FAIL limpiar_clear got v=%0d s=%b o=%b i=%b exp all 0", velocidad, saturado, ocupado, impulso);
        else n_pass++;
        n_checks++;
        if (ciclos !== CNT_W'(ref_ciclos)) $display("FAIL limpiar_ciclos got=%0d exp=%0d", ciclos, ref_ciclos);
        else n_pass++;
        n_imp = 0;
        repeat (LAT + 2) begin
            tick();
            if (impulso === 1'b1) n_imp++;
        end
        n_checks++;
        if (n_imp != 0) $display("FAIL limpiar_abort impulsos got=%0d exp=0", n_imp);
        else n_pass++;
        run_sample(-200, 25, 0, "after_limpiar");

        // limpiar wins over a simultaneous strobe
        aceleracion = 12'sd700;
        muestraValida = 1'b1;
        limpiar = 1'b1;
        tick();
        muestraValida = 1'b0;
        limpiar = 1'b0;
        ref_evt = edge_no;
        ref_vel = 0;
        ref_sat = 1'b0;
        ref_aprev = 0;
        n_imp = 0;
        repeat (LAT + 2) begin
            tick();
            if (impulso === 1'b1 || ocupado === 1'b1) n_imp++;
        end
        n_checks++;
        if (n_imp != 0 || velocidad !== '0)
            $display("FAIL limpiar_priority activity=%0d v=%0d exp 0/0", n_imp, velocidad);
        else n_pass++;
        run_sample(300, 40, 0, "after_priority");
    endtask

    task automatic test_random();
        int a, dtt, ex;
        for (int i = 0; i < 25; i++) begin
            a   = int'($urandom_range(0, 4095)) - 2048;
            dtt = int'($urandom_range(5, 260));
            ex  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, LAT)) : 0;
            run_sample(a, dtt, ex, "random");
        end
    endtask

    initial begin
        test_reset();
`ifdef INTEGRADOR_TRAPECIO_EN
        test_trapecio();
`else
        test_plan();
`endif
        test_back_to_back();
        test_limpiar();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
